// File: rtl/mul_booth_iter_if.sv
// Operand/result bundle for the iterative radix-4 Booth multiplier.
// The requester drives run and operands; the multiplier returns result/complete/busy.
// result and complete are registered inside the multiplier.
interface mul_booth_iter_if #(
  parameter int WIDTH = 32
);
  logic                 run;
  logic                 mul_signed;
  logic                 acc;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     y;
  logic [2*WIDTH-1:0]   result;
  logic                 complete;
  logic                 busy;

  modport master (
    output run, mul_signed, acc, x, y,
    input  result, complete, busy
  );

  modport slave (
    input  run, mul_signed, acc, x, y,
    output result, complete, busy
  );
endinterface

// File: rtl/mul_booth_iter.sv
// Iterative radix-4 Booth multiplier with optional accumulate into the last result.
// Latency: WIDTH/2+2 cycles from the run-capture edge to the one-cycle complete pulse.
// Backpressure: run is a level request; dropping it mid-calculation aborts the operation.
module mul_booth_iter #(
  parameter int WIDTH  = 32,
  parameter int ACC_EN = 1
) (
  input  logic mul_clk,
  input  logic resetn,
  mul_booth_iter_if.slave bus
);

  localparam int NDIG = WIDTH / 2 + 1;      // digits in a (WIDTH+2)-bit multiplier
  localparam int CW   = $clog2(NDIG + 1);
  localparam int XW   = WIDTH + 2;
  localparam int PW   = 2 * WIDTH + 2;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [PW-1:0]       mcand;       // multiplicand, pre-shifted to the current digit weight
  logic [PW-1:0]       accum;       // running sum of partial products
  logic [PW-1:0]       pp;
  logic [XW-1:0]       mplr;        // multiplier, shifted right two bits per digit
  logic                mplr_prev;   // bit just below the current digit pair
  logic                acc_q;
  logic [2*WIDTH-1:0]  result_q;
  logic                complete_q;
  logic                busy_q;

  logic                x_sx;
  logic                y_sx;
  logic [XW-1:0]       x_ext;
  logic [XW-1:0]       y_ext;

  // Two extra bits make unsigned operands representable as positive two's-complement values.
  assign x_sx  = bus.mul_signed & bus.x[WIDTH-1];
  assign y_sx  = bus.mul_signed & bus.y[WIDTH-1];
  assign x_ext = {{2{x_sx}}, bus.x};
  assign y_ext = {{2{y_sx}}, bus.y};

  assign bus.result   = result_q;
  assign bus.complete = complete_q;
  assign bus.busy     = busy_q;

  // Booth digit decode: select 0, +-X or +-2X from the current digit window.
  always_comb begin
    pp = '0;
    unique case ({mplr[1:0], mplr_prev})
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = mcand << 1;
      3'b100:         pp = -(mcand << 1);
      3'b101, 3'b110: pp = -mcand;
      default:        pp = '0;
    endcase
  end

  // Control FSM and datapath: capture, retire one digit per cycle, then publish the result.
  always_ff @(posedge mul_clk) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      mcand      <= '0;
      accum      <= '0;
      mplr       <= '0;
      mplr_prev  <= 1'b0;
      acc_q      <= 1'b0;
      result_q   <= '0;
      complete_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      complete_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.run) begin
            mcand     <= {{WIDTH{x_ext[XW-1]}}, x_ext};
            mplr      <= y_ext;
            mplr_prev <= 1'b0;
            accum     <= '0;
            acc_q     <= (ACC_EN != 0) & bus.acc;
            cnt       <= '0;
            busy_q    <= 1'b1;
            state     <= CALC;
          end
        end
        CALC: begin
          if (!bus.run) begin
            // Abort leaves the published result untouched.
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (cnt == CW'(NDIG)) begin
            result_q   <= acc_q ? result_q + accum[2*WIDTH-1:0] : accum[2*WIDTH-1:0];
            complete_q <= 1'b1;
            state      <= DONE;
          end else begin
            accum     <= accum + pp;
            mcand     <= mcand << 2;
            mplr      <= {{2{mplr[XW-1]}}, mplr[XW-1:2]};
            mplr_prev <= mplr[1];
            cnt       <= cnt + 1'b1;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
